// File: rtl/period_meter.sv
// Measures the clk-cycle distance between consecutive rising edges of pulse_in,
// with a 1-cycle valid strobe per measurement and a timeout strobe on loss of edges.
module period_meter #(
    parameter int unsigned PERIOD_MAX  = 27000001,
    parameter int unsigned MIN_PERIOD  = 1,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned W = $clog2(PERIOD_MAX + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         pulse_in,
    output logic [W-1:0] period,
    output logic         period_valid,
    output logic         timeout,
    output logic         locked
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;

    localparam logic [W-1:0] CNT_ONE = W'(1);
    localparam logic [W-1:0] CNT_MAX = W'(PERIOD_MAX);
    localparam logic [W-1:0] CNT_MIN = W'(MIN_PERIOD);

    logic       s_c;
    logic       rise_c;
    logic       s_d_q;
    logic       s_d_d;

    logic [1:0]   state_q;
    logic [1:0]   state_d;
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W-1:0] period_q;
    logic [W-1:0] period_d;
    logic         period_valid_q;
    logic         period_valid_d;
    logic         timeout_q;
    logic         timeout_d;
    logic         locked_q;
    logic         locked_d;

    // Input synchronizer; bypassed when pulse_in is already in the clk domain.
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s_c = pulse_in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            logic [SYNC_STAGES-1:0] sync_d;

            always_comb begin
                sync_d    = sync_q;
                sync_d[0] = pulse_in;
                for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                    sync_d[i] = sync_q[i-1];
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= sync_d;
                end
            end

            assign s_c = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // Edge history cleared by reset, so a level held high across release counts once.
    always_comb begin
        s_d_d  = s_c;
        rise_c = s_c & ~s_d_q;
    end

    // Next-state, counter and output logic.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        timeout_d      = 1'b0;
        locked_d       = locked_q;

        case (state_q)
            ST_IDLE, ST_TIMEOUT: begin
                if (rise_c) begin
                    state_d = ST_MEASURE;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_MEASURE: begin
                // An accepted edge wins over the saturation cycle.
                if (rise_c && (cnt_q >= CNT_MIN)) begin
                    period_d       = cnt_q;
                    period_valid_d = 1'b1;
                    locked_d       = 1'b1;
                    cnt_d          = CNT_ONE;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = ST_TIMEOUT;
                    timeout_d = 1'b1;
                    locked_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_d_q          <= 1'b0;
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            timeout_q      <= 1'b0;
            locked_q       <= 1'b0;
        end else begin
            s_d_q          <= s_d_d;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            timeout_q      <= timeout_d;
            locked_q       <= locked_d;
        end
    end

    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign timeout      = timeout_q;
    assign locked       = locked_q;

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: a per-cycle vector table for reset and steady
// measurement, plus hand-written sequences for timeout, glitch reject and reset corners.
module tb_period_meter;

    localparam int unsigned PMAX = 20;
    localparam int unsigned TW   = $clog2(PMAX + 1);
    localparam int NVEC = 43;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pulse_a = 1'b0;
    logic          pulse_b = 1'b0;
    logic [TW-1:0] period_a;
    logic [TW-1:0] period_b;
    logic          valid_a;
    logic          valid_b;
    logic          timeout_a;
    logic          timeout_b;
    logic          locked_a;
    logic          locked_b;

    int checks = 0;
    int errors = 0;
    bit sel_b  = 1'b0;

    always #5 clk = ~clk;

    period_meter #(.PERIOD_MAX(PMAX), .MIN_PERIOD(1), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .pulse_in(pulse_a),
        .period(period_a), .period_valid(valid_a), .timeout(timeout_a), .locked(locked_a)
    );

    period_meter #(.PERIOD_MAX(PMAX), .MIN_PERIOD(4), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .pulse_in(pulse_b),
        .period(period_b), .period_valid(valid_b), .timeout(timeout_b), .locked(locked_b)
    );

    typedef struct {
        logic          rst_n;
        logic          pulse;
        logic [TW-1:0] period;
        logic          valid;
        logic          timeout;
        logic          locked;
    } vec_t;

    vec_t vecs[NVEC];

    // Drive one cycle on the selected instance and compare its outputs after the edge.
    task automatic drive_chk(input string name, input logic r, input logic p,
                             input logic [TW-1:0] per, input logic v,
                             input logic t, input logic l);
        logic [TW-1:0] gp;
        logic gv, gt, gl;
        @(negedge clk);
        rst_n = r;
        if (sel_b) begin
            pulse_b = p;
            pulse_a = 1'b0;
        end else begin
            pulse_a = p;
            pulse_b = 1'b0;
        end
        @(posedge clk);
        #1;
        gp = sel_b ? period_b  : period_a;
        gv = sel_b ? valid_b   : valid_a;
        gt = sel_b ? timeout_b : timeout_a;
        gl = sel_b ? locked_b  : locked_a;
        checks++;
        if (gp !== per || gv !== v || gt !== t || gl !== l) begin
            errors++;
            $display("FAIL %s: got period=%0d valid=%b timeout=%b locked=%b, expected period=%0d valid=%b timeout=%b locked=%b",
                     name, gp, gv, gt, gl, per, v, t, l);
        end
    endtask

    task automatic cyc(input string name, input logic p, input logic [TW-1:0] per,
                       input logic v, input logic t, input logic l);
        drive_chk(name, 1'b1, p, per, v, t, l);
    endtask

    task automatic quiet(input string name, input int n, input logic [TW-1:0] per,
                         input logic l);
        for (int i = 0; i < n; i++) begin
            cyc(name, 1'b0, per, 1'b0, 1'b0, l);
        end
    endtask

    task automatic do_reset(input string name, input logic p);
        for (int i = 0; i < 2; i++) begin
            drive_chk(name, 1'b0, p, '0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        // Reset with toggling input, then 1-cycle pulses every 10 cycles x4.
        for (int i = 0; i < NVEC; i++) begin
            int k;
            k = i - 3;
            vecs[i].timeout = 1'b0;
            if (i < 3) begin
                vecs[i].rst_n  = 1'b0;
                vecs[i].pulse  = (i != 1);
                vecs[i].period = '0;
                vecs[i].valid  = 1'b0;
                vecs[i].locked = 1'b0;
            end else begin
                vecs[i].rst_n  = 1'b1;
                vecs[i].pulse  = (k % 10 == 0) && (k <= 30);
                vecs[i].period = (k >= 12) ? TW'(10) : TW'(0);
                vecs[i].valid  = (k == 12) || (k == 22) || (k == 32);
                vecs[i].locked = (k >= 12);
            end
        end

        sel_b = 1'b0;
        for (int i = 0; i < NVEC; i++) begin
            drive_chk($sformatf("vec %0d", i), vecs[i].rst_n, vecs[i].pulse,
                      vecs[i].period, vecs[i].valid, vecs[i].timeout, vecs[i].locked);
        end

        // Period equal to PERIOD_MAX, then timeout, re-acquire, period 7.
        do_reset("t3 reset", 1'b0);
        cyc("t3 e0", 1'b1, TW'(0), 1'b0, 1'b0, 1'b0);
        quiet("t3 q0", 19, TW'(0), 1'b0);
        cyc("t3 e1", 1'b1, TW'(0), 1'b0, 1'b0, 1'b0);
        quiet("t3 q1", 1, TW'(0), 1'b0);
        cyc("t3 s1", 1'b0, TW'(20), 1'b1, 1'b0, 1'b1);
        quiet("t3 q2", 17, TW'(20), 1'b1);
        cyc("t3 e2", 1'b1, TW'(20), 1'b0, 1'b0, 1'b1);
        quiet("t3 q3", 1, TW'(20), 1'b1);
        cyc("t3 s2", 1'b0, TW'(20), 1'b1, 1'b0, 1'b1);
        quiet("t3 q4", 19, TW'(20), 1'b1);
        cyc("t3 tmo", 1'b0, TW'(20), 1'b0, 1'b1, 1'b0);
        quiet("t3 q5", 2, TW'(20), 1'b0);
        cyc("t3 e3", 1'b1, TW'(20), 1'b0, 1'b0, 1'b0);
        quiet("t3 first-again", 6, TW'(20), 1'b0);
        cyc("t3 e4", 1'b1, TW'(20), 1'b0, 1'b0, 1'b0);
        quiet("t3 q6", 1, TW'(20), 1'b0);
        cyc("t3 s7", 1'b0, TW'(7), 1'b1, 1'b0, 1'b1);
        quiet("t3 q7", 2, TW'(7), 1'b1);

        // Glitch reject on the MIN_PERIOD=4 instance.
        sel_b = 1'b1;
        do_reset("t4 reset", 1'b0);
        cyc("t4 e0", 1'b1, TW'(0), 1'b0, 1'b0, 1'b0);
        cyc("t4 gap", 1'b0, TW'(0), 1'b0, 1'b0, 1'b0);
        cyc("t4 e2", 1'b1, TW'(0), 1'b0, 1'b0, 1'b0);
        quiet("t4 ignored", 7, TW'(0), 1'b0);
        cyc("t4 e10", 1'b1, TW'(0), 1'b0, 1'b0, 1'b0);
        quiet("t4 q", 1, TW'(0), 1'b0);
        cyc("t4 s10", 1'b0, TW'(10), 1'b1, 1'b0, 1'b1);
        quiet("t4 after", 3, TW'(10), 1'b1);
        sel_b = 1'b0;

        // Input held high across reset release and for 50 cycles: one edge, then timeout.
        do_reset("t5 reset", 1'b1);
        for (int s = 0; s < 50; s++) begin
            cyc($sformatf("t5 hold %0d", s), 1'b1, TW'(0), 1'b0, (s == 22), 1'b0);
        end
        quiet("t5 release", 3, TW'(0), 1'b0);

        // Reset mid-measurement after lock, then fresh acquisition.
        do_reset("t6 reset", 1'b0);
        cyc("t6 e0", 1'b1, TW'(0), 1'b0, 1'b0, 1'b0);
        quiet("t6 q0", 9, TW'(0), 1'b0);
        cyc("t6 e1", 1'b1, TW'(0), 1'b0, 1'b0, 1'b0);
        quiet("t6 q1", 1, TW'(0), 1'b0);
        cyc("t6 s10", 1'b0, TW'(10), 1'b1, 1'b0, 1'b1);
        quiet("t6 q2", 5, TW'(10), 1'b1);
        drive_chk("t6 mid-reset", 1'b0, 1'b0, TW'(0), 1'b0, 1'b0, 1'b0);
        quiet("t6 q3", 5, TW'(0), 1'b0);
        cyc("t6 e5", 1'b1, TW'(0), 1'b0, 1'b0, 1'b0);
        quiet("t6 first-edge", 7, TW'(0), 1'b0);
        cyc("t6 e13", 1'b1, TW'(0), 1'b0, 1'b0, 1'b0);
        quiet("t6 q4", 1, TW'(0), 1'b0);
        cyc("t6 s8", 1'b0, TW'(8), 1'b1, 1'b0, 1'b1);
        quiet("t6 q5", 2, TW'(8), 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
